mcpu_core_f2d_queue: RTL and testbench

MCPU_CORE_F2D_QUEUE -- requirements
Module: MCPU_CORE_f2d_queue

---
 rtl/mcpu_core_f2d_queue.sv | 70 +++++++
 tb/tb_mcpu_core_f2d_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_f2d_queue.sv
// mcpu_core_f2d_queue: fetch-to-decode instruction packet queue.
//   clkrst_core_clk/clkrst_core_rst : core clock, synchronous active-high reset
//   f2q_valid/f2q_virtpc/f2q_packet : packet pushed from fetch
//   q2f_ok                          : fetch may issue another I$ request
//   pipe_flush                      : discard every queued packet
//   q2d_valid/q2d_virtpc/q2d_packet : head entry toward decode
//   d2q_ready                       : decode consumes the head entry
//   q_overflow                      : sticky, a push was dropped on a full queue
module mcpu_core_f2d_queue #(
    parameter int DEPTH = 4,
    parameter int PW    = 128
) (
    input  logic          clkrst_core_clk,
    input  logic          clkrst_core_rst,
    input  logic          f2q_valid,
    input  logic [27:0]   f2q_virtpc,
    input  logic [PW-1:0] f2q_packet,
    output logic          q2f_ok,
    input  logic          pipe_flush,
    output logic          q2d_valid,
    output logic [27:0]   q2d_virtpc,
    output logic [PW-1:0] q2d_packet,
    input  logic          d2q_ready,
    output logic          q_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL   = (AW+1)'(DEPTH);
    // one slot stays free for the request already in flight at the I$
    localparam logic [AW:0] L_OK_MAX = (AW+1)'(DEPTH - 2);

    logic [27+PW:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_overflow;
    logic           w_pop, w_push, w_drop;

    assign w_pop  = (r_count != '0) & d2q_ready & ~pipe_flush;
    assign w_push = f2q_valid & ~pipe_flush & ((r_count != L_FULL) | w_pop);
    assign w_drop = f2q_valid & ~pipe_flush & ~w_push;

    assign q2d_valid                = r_count != '0;
    assign {q2d_virtpc, q2d_packet} = r_mem[r_rd_ptr];
    assign q2f_ok                   = (r_count <= L_OK_MAX) & ~pipe_flush;
    assign q_overflow               = r_overflow;

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (pipe_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr   <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr   <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count    <= (w_push & ~w_pop) ? r_count + (AW+1)'(1) :
                          (w_pop & ~w_push) ? r_count - (AW+1)'(1) : r_count;
            r_overflow <= r_overflow | w_drop;
        end
    end

    // storage is not reset; only the pointers qualify its contents
    always_ff @(posedge clkrst_core_clk) begin
        if (w_push && !clkrst_core_rst)
            r_mem[r_wr_ptr] <= {f2q_virtpc, f2q_packet};
    end
endmodule

// File: tb/tb_mcpu_core_f2d_queue.sv
// tb_mcpu_core_f2d_queue: table-driven and scoreboard bench for the fetch-to-decode queue.
module tb_mcpu_core_f2d_queue;
    localparam int DEPTH = 4;
    localparam int PW    = 128;

    logic          clk = 1'b0;
    logic          rst, f_valid, ready, flush;
    logic [27:0]   f_vpc;
    logic [PW-1:0] f_pkt;
    logic          ok, d_valid, ovf;
    logic [27:0]   d_vpc;
    logic [PW-1:0] d_pkt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcpu_core_f2d_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .f2q_valid(f_valid),
        .f2q_virtpc(f_vpc),
        .f2q_packet(f_pkt),
        .q2f_ok(ok),
        .pipe_flush(flush),
        .q2d_valid(d_valid),
        .q2d_virtpc(d_vpc),
        .q2d_packet(d_pkt),
        .d2q_ready(ready),
        .q_overflow(ovf)
    );

    function automatic logic [PW-1:0] pkt(input logic [27:0] v);
        return {4{4'h5, v}};
    endfunction

    task automatic check(input string name, input logic [PW+27:0] act, input logic [PW+27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: a plain queue of {virtpc, packet}, updated at the
    // sampling point with the inputs that the next rising edge will see
    logic [PW+27:0] sb[$];
    logic           m_ovf   = 1'b0;
    logic           m_known = 1'b0;

    always @(negedge clk) begin
        logic m_pop, m_push;
        if (rst) begin
            sb.delete();
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            check("sb_valid", d_valid, sb.size() != 0);
            check("sb_ok", ok, sb.size() <= DEPTH - 2 && !flush);
            check("sb_ovf", ovf, m_ovf);
            if (sb.size() != 0) check("sb_head", {d_vpc, d_pkt}, sb[0]);
            m_pop  = sb.size() != 0 && ready && !flush;
            m_push = f_valid && !flush && (sb.size() < DEPTH || m_pop);
            if (flush) sb.delete();
            else begin
                if (m_pop) void'(sb.pop_front());
                if (m_push) sb.push_back({f_vpc, pkt(f_vpc)});
                if (f_valid && !m_push) m_ovf = 1'b1;
            end
        end
    end

    typedef struct {
        logic        rst, v;
        logic [27:0] vpc;
        logic        rdy, fl, chk, ev, eok, eovf, cv;
        logic [27:0] evpc;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic r, input logic v, input logic [27:0] vpc, input logic rd, input logic fl);
        @(posedge clk);
        #1;
        rst     = r;
        f_valid = v;
        f_vpc   = vpc;
        f_pkt   = pkt(vpc);
        ready   = rd;
        flush   = fl;
    endtask

    initial begin
        rst = 1'b1; f_valid = 1'b0; f_vpc = '0; f_pkt = '0; ready = 1'b0; flush = 1'b0;
        //               rst v  vpc      rdy fl chk ev eok eovf cv evpc
        tbl.push_back('{1, 0, 28'h0,  0, 0, 0, 0, 0, 0, 0, 28'h0});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 0, 1, 0, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h10, 0, 0, 1, 0, 1, 0, 0, 28'h0});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 1, 1, 0, 1, 28'h10});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 1, 1, 0, 1, 28'h10});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 1, 1, 0, 1, 28'h10});
        tbl.push_back('{0, 0, 28'h0,  1, 0, 1, 1, 1, 0, 1, 28'h10});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 0, 1, 0, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h0,  0, 0, 1, 0, 1, 0, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h1,  0, 0, 1, 1, 1, 0, 1, 28'h0});
        tbl.push_back('{0, 1, 28'h2,  0, 0, 1, 1, 1, 0, 1, 28'h0});
        tbl.push_back('{0, 1, 28'h3,  0, 0, 1, 1, 0, 0, 1, 28'h0});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 1, 0, 0, 1, 28'h0});
        tbl.push_back('{0, 1, 28'h5,  0, 0, 1, 1, 0, 0, 1, 28'h0});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 1, 0, 1, 1, 28'h0});
        tbl.push_back('{0, 1, 28'h9,  1, 0, 1, 1, 0, 1, 1, 28'h0});
        tbl.push_back('{0, 0, 28'h0,  1, 0, 1, 1, 0, 1, 1, 28'h1});
        tbl.push_back('{0, 0, 28'h0,  1, 0, 1, 1, 0, 1, 1, 28'h2});
        tbl.push_back('{0, 0, 28'h0,  1, 0, 1, 1, 1, 1, 1, 28'h3});
        tbl.push_back('{0, 0, 28'h0,  1, 0, 1, 1, 1, 1, 1, 28'h9});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 0, 1, 1, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h20, 0, 0, 1, 0, 1, 1, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h21, 0, 0, 1, 1, 1, 1, 1, 28'h20});
        tbl.push_back('{0, 1, 28'h22, 1, 1, 1, 1, 0, 1, 1, 28'h20});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 0, 1, 1, 0, 28'h0});
        tbl.push_back('{0, 1, 28'h30, 0, 0, 1, 0, 1, 1, 0, 28'h0});
        tbl.push_back('{1, 0, 28'h0,  0, 0, 1, 1, 1, 1, 1, 28'h30});
        tbl.push_back('{0, 0, 28'h0,  0, 0, 1, 0, 1, 0, 0, 28'h0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].vpc, tbl[i].rdy, tbl[i].fl);
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("row%0d_valid", i), d_valid, tbl[i].ev);
                check($sformatf("row%0d_ok", i), ok, tbl[i].eok);
                check($sformatf("row%0d_ovf", i), ovf, tbl[i].eovf);
                if (tbl[i].cv) begin
                    check($sformatf("row%0d_vpc", i), d_vpc, tbl[i].evpc);
                    check($sformatf("row%0d_pkt", i), d_pkt, pkt(tbl[i].evpc));
                end
            end
        end

        // streaming: push every other cycle with decode always ready, so the
        // occupancy toggles 0/1 while both pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, i % 2 == 0, 28'h40 + 28'(i / 2), 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("stream%0d_valid", i), d_valid, i % 2 == 1);
            if (i % 2 == 1) check($sformatf("stream%0d_vpc", i), d_vpc, 28'h40 + 28'(i / 2));
        end

        // back-to-back streaming with a continuous push and pop
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 28'h60 + 28'(i), 1'b1, 1'b0);

        // random traffic checked entirely by the scoreboard
        for (int i = 0; i < 400; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 28'($urandom), 1'($urandom_range(0, 2) != 0),
                  $urandom_range(0, 29) == 0);

        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("drained_valid", d_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
